// File: rtl/alu_rx_interface.sv
// Collects operand A, operand B and an op code from a UART receiver, then sends
// the external ALU result back through the UART transmitter.
module alu_rx_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_timeout,
    output logic               o_overrun,
    output logic [2:0]         o_state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
    logic             ld_a, ld_b, ld_op, ld_tx;
    logic             tmo_nx, ovr_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_A;
            idle_cnt <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_cnt_nx;
        end
    end

    // Idle counter only runs while waiting for B or OP; every other path clears it.
    always_comb begin
        state_nx    = state;
        idle_cnt_nx = '0;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        ld_op       = 1'b0;
        ld_tx       = 1'b0;
        tmo_nx      = 1'b0;
        ovr_set     = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    ld_a     = 1'b1;
                    state_nx = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    ld_b     = 1'b1;
                    state_nx = WAIT_OP;
                end else if (idle_cnt == CNT_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = WAIT_A;
                end else begin
                    idle_cnt_nx = idle_cnt + CNT_W'(1);
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    ld_op    = 1'b1;
                    state_nx = SEND;
                end else if (idle_cnt == CNT_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = WAIT_A;
                end else begin
                    idle_cnt_nx = idle_cnt + CNT_W'(1);
                end
            end
            SEND: begin
                ld_tx    = 1'b1;
                ovr_set  = i_rx_done;
                state_nx = WAIT_TX;
            end
            WAIT_TX: begin
                ovr_set = i_rx_done;
                if (i_tx_done) state_nx = WAIT_A;
            end
            default: state_nx = WAIT_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            if (ld_a)  o_data_a  <= i_rx_data;
            if (ld_b)  o_data_b  <= i_rx_data;
            if (ld_op) o_op      <= i_rx_data[NB_OP-1:0];
            if (ld_tx) o_tx_data <= i_alu_result;
            o_tx_start <= ld_tx;
            o_timeout  <= tmo_nx;
            o_overrun  <= o_overrun | ovr_set;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_rx_interface.sv
// Directed bench: stimulus pushes expected transactions/timeouts into queues,
// a negedge monitor pops and compares whenever the DUT pulses tx_start or timeout.
module tb_alu_rx_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TIMEOUT = 16;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               i_rx_done = 1'b0;
    logic [NB_DATA-1:0] i_rx_data = '0;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done = 1'b0;
    logic [NB_DATA-1:0] o_data_a, o_data_b, o_tx_data;
    logic [NB_OP-1:0]   o_op;
    logic               o_tx_start, o_timeout, o_overrun;
    logic [2:0]         o_state;

    always #5 clock = ~clock;

    alu_rx_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_data_a(o_data_a),
        .o_data_b(o_data_b), .o_op(o_op), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .o_timeout(o_timeout), .o_overrun(o_overrun), .o_state(o_state)
    );

    // Combinational ALU model the DUT drives through its operand registers
    always_comb begin
        i_alu_result = '0;
        case (o_op)
            6'h20: i_alu_result = o_data_a + o_data_b;
            6'h22: i_alu_result = o_data_a - o_data_b;
            6'h24: i_alu_result = o_data_a & o_data_b;
            6'h25: i_alu_result = o_data_a | o_data_b;
            6'h26: i_alu_result = o_data_a ^ o_data_b;
            6'h27: i_alu_result = ~(o_data_a | o_data_b);
            6'h02: i_alu_result = o_data_a >> o_data_b;
            6'h03: i_alu_result = $signed(o_data_a) >>> o_data_b;
            default: i_alu_result = '0;
        endcase
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] tx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tmo_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        logic [7:0] ta;
        if (reset) begin
            if (o_tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_start actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_tx_data", o_tx_data, e.tx);
                    chk("sb_op", o_op, e.op);
                    chk("sb_data_a", o_data_a, e.a);
                    chk("sb_data_b", o_data_b, e.b);
                end
            end
            if (o_timeout) begin
                if (tmo_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_timeout actual=1 required=0");
                end else begin
                    ta = tmo_q.pop_front();
                    chk("sb_tmo_state", o_state, 0);
                    chk("sb_tmo_data_a", o_data_a, ta);
                end
            end
        end
    end

    // Called at a negedge; byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clock);
        i_rx_done = 1'b0;
    endtask

    // mode 0: plain tx_done; 1: stray byte while in WAIT_TX; 2: rx and tx done together
    task automatic finish_txn(input logic [7:0] a, input logic [7:0] b, input int mode);
        int n = 0;
        while (!o_tx_start && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("tx_start_seen", o_tx_start, 1);
        @(negedge clock);
        @(negedge clock);
        chk("hold_wait_tx", o_state, 4);
        if (mode == 1) begin
            send_byte(8'h55);
            chk("ovr_set", o_overrun, 1);
            chk("ovr_state", o_state, 4);
            chk("ovr_no_latch_a", o_data_a, a);
        end
        if (mode == 2) begin
            i_rx_data = 8'h99;
            i_rx_done = 1'b1;
            i_tx_done = 1'b1;
            @(negedge clock);
            i_rx_done = 1'b0;
            i_tx_done = 1'b0;
            chk("both_state", o_state, 0);
            chk("both_ovr", o_overrun, 1);
            chk("both_a", o_data_a, a);
            chk("both_b", o_data_b, b);
        end else begin
            i_tx_done = 1'b1;
            @(negedge clock);
            i_tx_done = 1'b0;
            chk("back_to_a", o_state, 0);
        end
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [5:0] eop, input logic [7:0] tx, input int mode);
        exp_q.push_back('{a: a, b: b, op: eop, tx: tx});
        send_byte(a);
        @(negedge clock);
        send_byte(b);
        send_byte(op);
        finish_txn(a, b, mode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_state", o_state, 0);
        chk("rst_outs", {o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_timeout, o_overrun}, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_state", o_state, 0);

        // ADD with state walk and latency
        exp_q.push_back('{a: 8'h03, b: 8'h02, op: 6'h20, tx: 8'h05});
        send_byte(8'h03);
        chk("walk_b", o_state, 1);
        chk("lat_a", o_data_a, 8'h03);
        send_byte(8'h02);
        chk("walk_op", o_state, 2);
        send_byte(8'h20);
        chk("walk_send", o_state, 3);
        chk("no_start_yet", o_tx_start, 0);
        @(negedge clock);
        chk("walk_tx", o_state, 4);
        chk("start_latency", o_tx_start, 1);
        finish_txn(8'h03, 8'h02, 0);
        @(negedge clock);
        chk("hold_tx_data", o_tx_data, 8'h05);

        // AND with upper op bits dropped
        run_txn(8'h03, 8'h02, 8'hE4, 6'h24, 8'h02, 0);

        // Timeout after 16 idle cycles in WAIT_B; tx_done there is ignored
        tmo_q.push_back(8'h11);
        send_byte(8'h11);
        i_tx_done = 1'b1;
        @(negedge clock);
        i_tx_done = 1'b0;
        chk("txdone_ignored", o_state, 1);
        repeat (14) @(negedge clock);
        chk("pre_tmo_state", o_state, 1);
        chk("pre_tmo_flag", o_timeout, 0);
        @(negedge clock);
        chk("tmo_pulse", o_timeout, 1);
        chk("tmo_state", o_state, 0);
        @(negedge clock);
        chk("tmo_one_cycle", o_timeout, 0);
        run_txn(8'h04, 8'h02, 8'h20, 6'h20, 8'h06, 0);

        // Byte arriving in the last idle cycle is accepted
        exp_q.push_back('{a: 8'h0F, b: 8'h01, op: 6'h25, tx: 8'h0F});
        send_byte(8'h0F);
        repeat (15) @(negedge clock);
        send_byte(8'h01);
        chk("edge_state", o_state, 2);
        chk("edge_no_tmo", o_timeout, 0);
        send_byte(8'h25);
        finish_txn(8'h0F, 8'h01, 0);

        // Overrun is sticky
        chk("ovr_clear", o_overrun, 0);
        run_txn(8'h0A, 8'h05, 8'h26, 6'h26, 8'h0F, 1);
        run_txn(8'h81, 8'h01, 8'h02, 6'h02, 8'h40, 0);
        chk("ovr_sticky", o_overrun, 1);

        // Async reset in WAIT_OP
        send_byte(8'h33);
        send_byte(8'h44);
        chk("pre_rst_op", o_state, 2);
        #2 reset = 1'b0;
        #1;
        chk("async_state", o_state, 0);
        chk("async_outs", {o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_timeout, o_overrun}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_txn(8'h07, 8'h01, 8'h22, 6'h22, 8'h06, 0);

        // rx_done and tx_done together in WAIT_TX
        chk("pre_both_ovr", o_overrun, 0);
        run_txn(8'h0C, 8'h0A, 8'h27, 6'h27, 8'hF1, 2);

        repeat (3) @(negedge clock);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("tmo_q_empty", tmo_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
